ahb2apb_bridge_mc: RTL and testbench
====================================

# ahb2apb_bridge_mc

Parametrised multi-slave AHB-Lite to APB3 bridge: the next-generation AHB2APB block, generalised to N APB slaves with address decode, configurable address/data width, PREADY wait states, PSLVERR-to-HRESP error mapping and a PREADY timeout. It sits between the AHB-Lite interconnect (as an AHB slave) and up to NUM_SLV APB peripherals. It drives one transfer at a time.

## Interface
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, data width (8, 16 or 32)
- NUM_SLV, 4, number of APB slaves (1..16, need not be a power of two)
- DEC_LSB, 12, lowest HADDR bit of the slave index field; index = haddr[DEC_LSB +: clog2(NUM_SLV)] (0 bits if NUM_SLV=1)
- TIMEOUT, 256, ACCESS cycles with PREADY low before forced error; 0 disables
- hclk  in  1  clock, all logic on rising edge
- hreset  in  1  asynchronous, active-high reset
- hsel  in  1  AHB slave select
- haddr  in  ADDR_W  AHB address
- htrans  in  2  AHB transfer type; only htrans[1]=1 (NONSEQ/SEQ) starts a transfer
- hwrite  in  1  1=write
- hsize  in  3  accepted, ignored (full-word APB access)
- hwdata  in  DATA_W  write data (AHB data phase)
- hready  in  1  bus-level HREADY
- hreadyout  out  1  bridge ready
- hresp  out  1  1=ERROR
- hrdata  out  DATA_W  read data
- paddr  out  ADDR_W  APB address
- psel  out  NUM_SLV  one-hot slave select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  NUM_SLV*DATA_W  slave i read data at [i*DATA_W +: DATA_W]
- pready  in  NUM_SLV  per-slave ready
- pslverr  in  NUM_SLV  per-slave error

## Operation
- States: IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2.
- Capture condition: hsel & hready & htrans[1], evaluated in IDLE and ERR2 only; registers haddr, hwrite, slave index.
- Capture, index < NUM_SLV: write -> LATCH, read -> SETUP. Index >= NUM_SLV -> ERR1, no APB activity.
- LATCH: register hwdata into pwdata -> SETUP.
- SETUP: psel[idx]=1, penable=0, paddr/pwrite valid -> ACCESS.
- ACCESS: psel[idx]=1, penable=1; samples pready[idx] / pslverr[idx] only.
  - pready=1, pslverr=0 -> IDLE; on reads hrdata <= prdata slice.
  - pready=1, pslverr=1 -> ERR1.
  - pready=0: stay; timeout counter increments; at counter == TIMEOUT-1 (TIMEOUT>0) -> ERR1, psel/penable drop.
- ERR1: hreadyout=0, hresp=1 -> ERR2. ERR2: hreadyout=1, hresp=1 -> IDLE, or capture a new transfer.
- hreadyout=1 only in IDLE and ERR2; hresp=1 only in ERR1/ERR2. All outputs registered.
- hrdata holds its last value on writes and errors; pwdata holds between writes; paddr/pwrite hold after a transfer.
- Timeout counter clears on every SETUP->ACCESS entry; width clog2(TIMEOUT+1).

## Timing
- Reset (async, immediate): state IDLE, hreadyout=1, hresp=0, hrdata=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, counter=0. Reset mid-transfer drops psel/penable in the same cycle; the transfer is lost.
- Capture at edge E0. Read, zero APB wait: SETUP in cycle after E0, ACCESS next, hreadyout=1 with data in the third cycle (2 AHB wait states). Write: 3 AHB wait states. Each PREADY-low cycle adds one.
- Unmapped address: ERR1 in the cycle after E0, ERR2 next.
- Back-to-back: a transfer presented during the completing hreadyout=1 cycle is captured. The next SETUP follows immediately, so psel is low for at least one cycle between transfers.
- Capture is ignored when hreadyout=0 (hready low); htrans IDLE/BUSY or hsel=0 never start a transfer.

## Test plan
- Write 0xDEADBEEF to 0x0000_1004 (slave 1), pready=1 -> paddr=0x1004, psel=4'b0010, pwrite=1, pwdata=0xDEADBEEF in SETUP/ACCESS, hreadyout low 3 cycles, hresp=0.
- Read 0x0000_3010 (slave 3), prdata slice 3=0x1234_5678, pready low 4 ACCESS cycles -> hrdata=0x12345678, 6 wait states total.
- Read slave 2 with pready=1, pslverr=1 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), hrdata unchanged.
- NUM_SLV=3, access 0x0000_3000 -> no psel asserted, two-cycle ERROR response.
- TIMEOUT=8, slave holds pready=0 -> after 8 ACCESS cycles psel/penable drop, two-cycle ERROR, then a following write completes normally.
- Reset asserted during ACCESS -> psel=0, penable=0, hreadyout=1 immediately; after release, a read returns correct data.

Source files
------------

// File: rtl/ahb2apb_bridge_mc.sv
// AHB-Lite to APB3 bridge for up to NUM_SLV slaves: one transfer at a time, PREADY
// wait states, PSLVERR mapped to a two-cycle AHB ERROR, and an optional PREADY timeout.
// state  | meaning
// IDLE   | ready for a new AHB transfer
// LATCH  | write data phase, capture hwdata
// SETUP  | APB setup phase
// ACCESS | APB access phase, waiting for pready
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle, may capture a new transfer
module ahb2apb_bridge_mc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int DEC_LSB = 12,
    parameter int TIMEOUT = 256
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [ADDR_W-1:0]         haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DATA_W-1:0]         hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [ADDR_W-1:0]         paddr,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, cap_idx, sel_idx;
    logic [CNT_W-1:0]    cnt;
    logic                capture, cap_mapped, sel_ready, sel_err, timeout_hit;
    logic [DATA_W-1:0]   sel_rdata;
    logic [NUM_SLV-1:0]  psel_nxt;
    logic                unused_ok;

    assign unused_ok = ^{hsize, htrans[0]};

    generate
        if (NUM_SLV > 1) begin : g_dec
            assign cap_idx = haddr[DEC_LSB +: IDX_W];
        end else begin : g_nodec
            assign cap_idx = '0;
        end
    endgenerate

    assign capture     = hsel & hready & htrans[1] & ((state == S_IDLE) | (state == S_ERR2));
    assign cap_mapped  = 32'(cap_idx) < NUM_SLV;
    assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);
    assign sel_idx     = capture ? cap_idx : idx;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (32'(idx) == i) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR2: begin
                if (capture) begin
                    if (!cap_mapped) state_nxt = S_ERR1;
                    else if (hwrite) state_nxt = S_LATCH;
                    else             state_nxt = S_SETUP;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LATCH:  state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready)        state_nxt = sel_err ? S_ERR1 : S_IDLE;
                else if (timeout_hit) state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        psel_nxt = '0;
        if (state_nxt == S_SETUP || state_nxt == S_ACCESS) psel_nxt[sel_idx] = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            hreadyout <= (state_nxt == S_IDLE) || (state_nxt == S_ERR2);
            hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
            psel      <= psel_nxt;
            penable   <= (state_nxt == S_ACCESS);
            if (capture && cap_mapped) begin
                paddr  <= haddr;
                pwrite <= hwrite;
                idx    <= cap_idx;
            end
            if (state == S_LATCH) pwdata <= hwdata;
            if (state == S_SETUP) cnt <= '0;
            else if (state == S_ACCESS && !sel_ready) cnt <= cnt + 1'b1;
            if (state == S_ACCESS && sel_ready && !sel_err && !pwrite) hrdata <= sel_rdata;
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge_mc.sv
// Directed bench for ahb2apb_bridge_mc: a vector table of AHB transfers against a
// behavioural APB slave, plus sequences for transfer filtering, unmapped decode and reset.
module tb_ahb2apb_bridge_mc;
    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel_a = 1'b0, hsel_b = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = '0;

    logic        hreadyout_a, hresp_a, penable_a, pwrite_a;
    logic [31:0] hrdata_a, paddr_a, pwdata_a;
    logic [3:0]  psel_a;
    logic [127:0] prdata_a = '0;
    logic [3:0]  pready_a = '0;
    logic [3:0]  pslverr_a;

    logic        hreadyout_b, hresp_b, penable_b, pwrite_b;
    logic [31:0] hrdata_b, paddr_b, pwdata_b;
    logic [2:0]  psel_b;
    logic [95:0] prdata_b = '0;
    logic [2:0]  pready_b = '1;
    logic [2:0]  pslverr_b = '0;

    int   cfg_low = 0;
    logic cfg_err = 1'b0;
    int   acc_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    assign pslverr_a = {4{cfg_err}};

    always #5 hclk = ~hclk;

    ahb2apb_bridge_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .DEC_LSB(12), .TIMEOUT(8)) dut_a (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(3'b010), .hwdata(hwdata), .hready(hreadyout_a),
        .hreadyout(hreadyout_a), .hresp(hresp_a), .hrdata(hrdata_a), .paddr(paddr_a),
        .psel(psel_a), .penable(penable_a), .pwrite(pwrite_a), .pwdata(pwdata_a),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

    ahb2apb_bridge_mc #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .DEC_LSB(12), .TIMEOUT(0)) dut_b (
        .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(3'b010), .hwdata(hwdata), .hready(hreadyout_b),
        .hreadyout(hreadyout_b), .hresp(hresp_b), .hrdata(hrdata_b), .paddr(paddr_b),
        .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b), .pwdata(pwdata_b),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

    // APB slave: holds pready low for cfg_low ACCESS cycles, then raises it.
    always @(negedge hclk) begin
        if (penable_a) acc_cnt = acc_cnt + 1;
        else           acc_cnt = 0;
        pready_a = {4{acc_cnt > cfg_low}};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int low, input logic err,
                           output int waits, output logic resp, output logic [3:0] psel_seen,
                           output logic [31:0] paddr_seen, output logic pwrite_seen,
                           output logic [31:0] pwdata_seen, output logic idle_ok);
        bit done = 0;
        cfg_low = low;
        cfg_err = err;
        for (int i = 0; i < 4; i++)
            prdata_a[i*32 +: 32] = (i == int'(addr[13:12])) ? rdata : ~rdata;
        hsel_a = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        @(posedge hclk);
        #1;
        hsel_a = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0; psel_seen = '0; paddr_seen = '0; pwrite_seen = 1'b0; pwdata_seen = '0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge hclk);
            if (psel_a != 0) begin
                psel_seen = psel_a; paddr_seen = paddr_a;
                pwrite_seen = pwrite_a; pwdata_seen = pwdata_a;
            end
            if (hreadyout_a) done = 1;
            else             waits++;
        end
        if (!done) check("xfer_timeout", 32'd0, 32'd1);
        resp = hresp_a;
        idle_ok = (psel_a == 0) && !penable_a;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          low;
        logic        err;
        int          exp_waits;
        logic        exp_resp;
        logic [3:0]  exp_psel;
        logic [31:0] exp_hrdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          waits;
        logic        resp, pw, idle_ok;
        logic [3:0]  ps;
        logic [31:0] pa, pd;
        bit          seen;

        vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEADBEEF, 32'h0,         0,   1'b0, 3,  1'b0, 4'b0010, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_3010, 32'h0,        32'h12345678,  4,   1'b0, 6,  1'b0, 4'b1000, 32'h12345678};
        vecs[2] = '{1'b0, 32'h0000_2000, 32'h0,        32'hAAAA5555,  0,   1'b1, 3,  1'b1, 4'b0100, 32'h12345678};
        vecs[3] = '{1'b0, 32'h0000_0008, 32'h0,        32'h0BADF00D,  0,   1'b0, 2,  1'b0, 4'b0001, 32'h0BADF00D};
        vecs[4] = '{1'b0, 32'h0000_1000, 32'h0,        32'h11111111,  100, 1'b0, 10, 1'b1, 4'b0010, 32'h0BADF00D};
        vecs[5] = '{1'b1, 32'h0000_2020, 32'h5A5AA5A5, 32'h0,         1,   1'b0, 4,  1'b0, 4'b0100, 32'h0BADF00D};
        vecs[6] = '{1'b0, 32'h0000_3004, 32'h0,        32'h77778888,  2,   1'b1, 5,  1'b1, 4'b1000, 32'h0BADF00D};
        vecs[7] = '{1'b0, 32'h0000_1FFC, 32'h0,        32'hCAFEF00D,  0,   1'b0, 2,  1'b0, 4'b0010, 32'hCAFEF00D};

        repeat (2) @(negedge hclk);
        check("rst_hreadyout", 32'(hreadyout_a), 32'd1);
        check("rst_hresp",     32'(hresp_a),     32'd0);
        check("rst_psel",      32'(psel_a),      32'd0);
        check("rst_hrdata",    hrdata_a,         32'h0);
        hreset = 1'b0;

        // hsel low, then BUSY: neither may start a transfer
        htrans = 2'b10; haddr = 32'h0000_1000;
        @(negedge hclk);
        check("nosel_hreadyout", 32'(hreadyout_a), 32'd1);
        check("nosel_psel",      32'(psel_a),      32'd0);
        hsel_a = 1'b1; htrans = 2'b01;
        @(negedge hclk);
        check("busy_hreadyout", 32'(hreadyout_a), 32'd1);
        check("busy_psel",      32'(psel_a),      32'd0);
        hsel_a = 1'b0; htrans = 2'b00;

        // Each transfer is presented in the completing cycle of the previous one.
        for (int v = 0; v < 8; v++) begin
            do_xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].low,
                    vecs[v].err, waits, resp, ps, pa, pw, pd, idle_ok);
            check($sformatf("v%0d_waits", v),  32'(waits),   32'(vecs[v].exp_waits));
            check($sformatf("v%0d_hresp", v),  32'(resp),    32'(vecs[v].exp_resp));
            check($sformatf("v%0d_psel", v),   32'(ps),      32'(vecs[v].exp_psel));
            check($sformatf("v%0d_paddr", v),  pa,           vecs[v].addr);
            check($sformatf("v%0d_pwrite", v), 32'(pw),      32'(vecs[v].wr));
            check($sformatf("v%0d_idle", v),   32'(idle_ok), 32'd1);
            check($sformatf("v%0d_hrdata", v), hrdata_a,     vecs[v].exp_hrdata);
            if (vecs[v].wr) check($sformatf("v%0d_pwdata", v), pd, vecs[v].wdata);
        end

        // Unmapped slave index on the three-slave bridge
        hsel_b = 1'b1; htrans = 2'b10; haddr = 32'h0000_3000; hwrite = 1'b0;
        @(posedge hclk);
        #1;
        hsel_b = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        check("unmap_err1_hreadyout", 32'(hreadyout_b), 32'd0);
        check("unmap_err1_hresp",     32'(hresp_b),     32'd1);
        check("unmap_err1_psel",      32'(psel_b),      32'd0);
        @(negedge hclk);
        check("unmap_err2_hreadyout", 32'(hreadyout_b), 32'd1);
        check("unmap_err2_hresp",     32'(hresp_b),     32'd1);
        check("unmap_err2_psel",      32'(psel_b),      32'd0);
        @(negedge hclk);
        check("unmap_done_hresp",     32'(hresp_b),     32'd0);

        // Reset asserted while a read is stalled in ACCESS
        cfg_low = 100; cfg_err = 1'b0;
        hsel_a = 1'b1; htrans = 2'b10; haddr = 32'h0000_3040; hwrite = 1'b0;
        @(posedge hclk);
        #1;
        hsel_a = 1'b0; htrans = 2'b00;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge hclk);
            if (penable_a) seen = 1;
        end
        check("rstmid_reached_access", 32'(seen), 32'd1);
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        check("rstmid_psel",      32'(psel_a),      32'd0);
        check("rstmid_penable",   32'(penable_a),   32'd0);
        check("rstmid_hreadyout", 32'(hreadyout_a), 32'd1);
        check("rstmid_hresp",     32'(hresp_a),     32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        do_xfer(1'b0, 32'h0000_3040, 32'h0, 32'h600DCAFE, 0, 1'b0, waits, resp, ps, pa, pw, pd, idle_ok);
        check("postrst_waits",  32'(waits), 32'd2);
        check("postrst_hresp",  32'(resp),  32'd0);
        check("postrst_psel",   32'(ps),    32'b1000);
        check("postrst_hrdata", hrdata_a,   32'h600DCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
